// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: input/output handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instrD;
    logic [2:0]       immSelD;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immD;
    logic [TAG_W-1:0] tag_out;
    logic             illegal;

    modport master (
        output flush, in_valid, instrD, immSelD, tag_in, out_ready,
        input  in_ready, out_valid, immD, tag_out, illegal
    );

    modport slave (
        input  flush, in_valid, instrD, immSelD, tag_in, out_ready,
        output in_ready, out_valid, immD, tag_out, illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate generator feeding a 2-entry FIFO; define IMM_CSR_ZIMM_EN to decode select 111 as CSR zimm
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic           clk,
    input logic           rst,
    imm_gen_pipe_if.slave bus
);
    logic [31:0]                 imm32;
    logic [XLEN-1:0]             imm_in;
    logic                        ill_in;
    logic                        push;
    logic                        pop;
    logic [1:0]                  count_q, count_d;
    logic                        wptr_q, wptr_d;
    logic                        rptr_q, rptr_d;
    logic [1:0][XLEN-1:0]        imm_q, imm_d;
    logic [1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [1:0]                  ill_q, ill_d;

    // Decode the immediate as a 32-bit value, then sign-extend to XLEN
    always_comb begin
        imm32  = '0;
        ill_in = 1'b0;
        case (bus.immSelD)
            3'b000: imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
            3'b001: imm32 = {{19{bus.instrD[31]}}, bus.instrD[31], bus.instrD[7],
                             bus.instrD[30:25], bus.instrD[11:8], 1'b0};
            3'b010: imm32 = {{11{bus.instrD[31]}}, bus.instrD[31], bus.instrD[19:12],
                             bus.instrD[20], bus.instrD[30:21], 1'b0};
            3'b011: imm32 = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
            3'b100: imm32 = {bus.instrD[31:12], 12'b0};
            3'b101: imm32 = '0;
            3'b110: imm32 = 32'd4;
            3'b111: begin
`ifdef IMM_CSR_ZIMM_EN
                imm32 = {27'b0, bus.instrD[19:15]};
`else
                ill_in = 1'b1;
`endif
            end
            default: imm32 = '0;
        endcase
        imm_in = XLEN'($signed(imm32));
    end

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // FIFO next state; flush empties the buffer and overrides push/pop
    always_comb begin
        imm_d   = imm_q;
        tag_d   = tag_q;
        ill_d   = ill_q;
        wptr_d  = push ? ~wptr_q : wptr_q;
        rptr_d  = pop ? ~rptr_q : rptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            imm_d[wptr_q] = imm_in;
            tag_d[wptr_q] = bus.tag_in;
            ill_d[wptr_q] = ill_in;
        end
        if (bus.flush) begin
            count_d = '0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end
    end

    // State registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            imm_q   <= '0;
            tag_q   <= '0;
            ill_q   <= '0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            imm_q   <= imm_d;
            tag_q   <= tag_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready  = count_q != 2'd2;
    assign bus.out_valid = count_q != 2'd0;
    assign bus.immD      = bus.out_valid ? imm_q[rptr_q] : '0;
    assign bus.tag_out   = bus.out_valid ? tag_q[rptr_q] : '0;
    assign bus.illegal   = bus.out_valid && ill_q[rptr_q];
endmodule
